// File: rtl/man_pkg.sv
// Shared constants and types for the Manhattan-distance datapath.
// Default geometry of the distance vectors and the occupancy-width helper.
package man_pkg;

    localparam int unsigned DIST_W  = 10;
    localparam int unsigned NCH_DEF = 8;
    localparam int unsigned TAG_W   = 8;

    typedef logic [NCH_DEF*DIST_W-1:0] dist_vec_t;

    // Bits needed to count 0..depth valid stages.
    function automatic int unsigned occ_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/man_pipe_stage.sv
// One pipeline slot: valid bit plus data and tag, with load enable and a valid-only clear.
// Clear drops the valid bit but keeps data/tag so a flushed pipe still shows its last payload.
module man_pipe_stage #(
    parameter int unsigned DW = 80,
    parameter int unsigned TW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    input  logic [TW-1:0] tag_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [TW-1:0] tag_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [TW-1:0] tag_q, tag_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = valid_i;
            data_d  = data_i;
            tag_d   = tag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/man_dist_pipe.sv
// Elastic register pipe for per-codeword distance vectors, DEPTH stages deep.
// Empty stages always accept from upstream, so a stalled pipe fills completely before stalling input.
module man_dist_pipe
    import man_pkg::*;
#(
    parameter int unsigned NCH   = NCH_DEF,
    parameter int unsigned W     = DIST_W,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAGW  = TAG_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NCH*W-1:0]             in_data,
    input  logic [TAGW-1:0]              in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NCH*W-1:0]             out_data,
    output logic [TAGW-1:0]              out_tag,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int unsigned DW   = NCH * W;
    localparam int unsigned OCCW = occ_width(DEPTH);

    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] v_q, v_d;
    logic [DW-1:0]    d_q [DEPTH];
    logic [TAGW-1:0]  t_q [DEPTH];
    logic [OCCW-1:0]  occ_q, occ_d;

    // A stage may advance when it is empty or everything downstream of it advances.
    always_comb begin
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !v_q[i] | rdy[i+1];
        end
    end

    assign in_ready = rdy[0] & !flush;

    // Mirror of the stage valid bits after this edge, used only for the occupancy count.
    always_comb begin
        v_d = v_q;
        if (rdy[0]) begin
            v_d[0] = in_valid;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (rdy[i]) begin
                v_d[i] = v_q[i-1];
            end
        end
        if (flush) begin
            v_d = '0;
        end
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCCW'(v_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic            vin;
        logic [DW-1:0]   din;
        logic [TAGW-1:0] tin;

        if (i == 0) begin : g_head
            assign vin = in_valid;
            assign din = in_data;
            assign tin = in_tag;
        end else begin : g_body
            assign vin = v_q[i-1];
            assign din = d_q[i-1];
            assign tin = t_q[i-1];
        end

        man_pipe_stage #(
            .DW (DW),
            .TW (TAGW)
        ) u_stage (
            .clk_i   (clk),
            .rst_i   (rst),
            .clr_i   (flush),
            .load_i  (rdy[i]),
            .valid_i (vin),
            .data_i  (din),
            .tag_i   (tin),
            .valid_o (v_q[i]),
            .data_o  (d_q[i]),
            .tag_o   (t_q[i])
        );
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign out_tag   = t_q[DEPTH-1];
    assign occupancy = occ_q;

endmodule
